// File: rtl/mux_nx1_monitor_if.sv
// ---------------------------------------------------------------------------
// mux_nx1_monitor_if
//   Observation bus between an N-input mux DUT and its checker.
//   The master side is whoever produces the mux stimulus and response (the
//   testbench). The slave side only observes (mux_nx1_monitor).
//
//   en       sample enable; 0 inserts a bubble
//   din      mux inputs; input i occupies din[i*WIDTH +: WIDTH]
//   sel      DUT select
//   mux_out  DUT output
// ---------------------------------------------------------------------------
interface mux_nx1_monitor_if #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 1
) ();
    localparam int SEL_W = $clog2(N_IN);

    logic                    en;
    logic [N_IN*WIDTH-1:0]   din;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        mux_out;

    modport master (output en, din, sel, mux_out);
    modport slave  (input  en, din, sel, mux_out);
endinterface

// File: rtl/mux_nx1_monitor.sv
// ---------------------------------------------------------------------------
// mux_nx1_monitor
//   Clocked checker for an N_IN-input, WIDTH-bit multiplexer whose output
//   lags sel/din by LATENCY cycles. Every enabled cycle it computes the
//   expected output din[sel]. It delays that expectation by LATENCY cycles
//   and compares it with mux_out. It counts failures, completed checks and
//   select changes, and it captures the first failure.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   clr            synchronous clear; returns to the reset state, wins over
//                  any check or count in the same cycle
//   bus            observed en / din / sel / mux_out (slave modport)
//   err_pulse      one-cycle pulse per failed check
//   illegal_sel    one-cycle pulse when a check with sel >= N_IN completes
//   err_sticky     set on the first failure, held until clr or reset
//   err_count      saturating count of failed checks
//   chk_count      saturating count of completed checks
//   sel_chg_count  saturating count of select changes between enabled samples
//   first_err_sel  sel of the first failing check
//   first_err_exp  expected value of the first failing check
//   first_err_got  mux_out of the first failing check
//
// Timing
//   A sample taken in cycle t is compared in cycle t+LATENCY. Its registered
//   results are visible from cycle t+LATENCY+1. With LATENCY=0 the compare
//   uses the live sample directly.
// ---------------------------------------------------------------------------
module mux_nx1_monitor #(
    parameter  int N_IN    = 4,
    parameter  int WIDTH   = 1,
    parameter  int LATENCY = 0,
    parameter  int CNT_W   = 16,
    localparam int SEL_W   = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    mux_nx1_monitor_if.slave     bus,
    output logic                 err_pulse,
    output logic                 illegal_sel,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     chk_count,
    output logic [CNT_W-1:0]     sel_chg_count,
    output logic [SEL_W-1:0]     first_err_sel,
    output logic [WIDTH-1:0]     first_err_exp,
    output logic [WIDTH-1:0]     first_err_got
);

    // One scheduled check. A bubble is an entry with valid=0.
    typedef struct packed {
        logic             valid;
        logic             illegal;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] exp;
    } entry_t;

    entry_t cur_entry;   // entry built from this cycle's sample
    entry_t cmp_entry;   // entry whose compare happens this cycle
    logic   check_fail;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Expected value. sel is decoded by an explicit match loop, so no
    // part-select ever reaches past din when sel >= N_IN. This matters
    // when N_IN is not a power of two. An unmatched sel stays tagged
    // illegal with exp = 0.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the loop; without it an
        // unmatched sel would leave fields unassigned and infer latches.
        cur_entry         = '0;
        cur_entry.valid   = bus.en;
        cur_entry.sel     = bus.sel;
        cur_entry.illegal = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                cur_entry.illegal = 1'b0;
                cur_entry.exp     = bus.din[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Expectation delay line, LATENCY entries deep.
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 0) begin : g_no_pipe
            assign cmp_entry = cur_entry;
        end else begin : g_pipe
            entry_t pipe [LATENCY];

            // NOTE: every stage is reset and cleared, not only the head. That
            // flushes checks in flight, so nothing stale completes after
            // reset or clr.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= cur_entry;
                    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign cmp_entry = pipe[LATENCY-1];
        end
    endgenerate

    // An illegal select fails even if mux_out happens to read 0.
    assign check_fail = cmp_entry.valid &&
                        (cmp_entry.illegal || (bus.mux_out != cmp_entry.exp));

    // ------------------------------------------------------------------
    // Check results, counters and first-error capture.
    // ------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments, so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse     <= 1'b0;
            illegal_sel   <= 1'b0;
            err_sticky    <= 1'b0;
            err_count     <= '0;
            chk_count     <= '0;
            first_err_sel <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (clr) begin
            err_pulse     <= 1'b0;
            illegal_sel   <= 1'b0;
            err_sticky    <= 1'b0;
            err_count     <= '0;
            chk_count     <= '0;
            first_err_sel <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            err_pulse   <= check_fail;
            illegal_sel <= cmp_entry.valid && cmp_entry.illegal;
            if (cmp_entry.valid) chk_count <= sat_inc(chk_count);
            if (check_fail) begin
                err_count  <= sat_inc(err_count);
                err_sticky <= 1'b1;
                // Only the first failure since reset/clr is captured.
                if (!err_sticky) begin
                    first_err_sel <= cmp_entry.sel;
                    first_err_exp <= cmp_entry.exp;
                    first_err_got <= bus.mux_out;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Select-change tracking. This works on the sampling side, so it is
    // not delayed by LATENCY. sel_seen suppresses counting on the first
    // enabled sample after reset/clr. en=0 cycles keep last_sel.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] last_sel;
    logic             sel_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sel      <= '0;
            sel_seen      <= 1'b0;
            sel_chg_count <= '0;
        end else if (clr) begin
            last_sel      <= '0;
            sel_seen      <= 1'b0;
            sel_chg_count <= '0;
        end else if (bus.en) begin
            last_sel <= bus.sel;
            sel_seen <= 1'b1;
            if (sel_seen && (bus.sel != last_sel))
                sel_chg_count <= sat_inc(sel_chg_count);
        end
    end

endmodule

// File: tb/tb_mux_nx1_monitor.sv
// ---------------------------------------------------------------------------
// tb_mux_nx1_monitor
//   Directed bench with three checker instances:
//     a: N_IN=4, WIDTH=1, LATENCY=0, CNT_W=16  (ideal DUT, en gaps, clr)
//     b: N_IN=4, WIDTH=8, LATENCY=2, CNT_W=16  (first-error capture)
//     c: N_IN=3, WIDTH=8, LATENCY=3, CNT_W=4   (illegal sel, saturation,
//                                               reset mid-flight)
//   Inputs change 1 ns after the rising edge. Outputs are read at that same
//   point, so they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_mux_nx1_monitor;

    logic clk = 1'b0;
    logic rst_n;
    logic a_clr, b_clr, c_clr;

    always #5 clk = ~clk;

    mux_nx1_monitor_if #(.N_IN(4), .WIDTH(1)) a_if ();
    mux_nx1_monitor_if #(.N_IN(4), .WIDTH(8)) b_if ();
    mux_nx1_monitor_if #(.N_IN(3), .WIDTH(8)) c_if ();

    logic        a_err_pulse, a_illegal_sel, a_err_sticky;
    logic [15:0] a_err_count, a_chk_count, a_sel_chg_count;
    logic [1:0]  a_first_err_sel;
    logic        a_first_err_exp, a_first_err_got;

    logic        b_err_pulse, b_illegal_sel, b_err_sticky;
    logic [15:0] b_err_count, b_chk_count, b_sel_chg_count;
    logic [1:0]  b_first_err_sel;
    logic [7:0]  b_first_err_exp, b_first_err_got;

    logic        c_err_pulse, c_illegal_sel, c_err_sticky;
    logic [3:0]  c_err_count, c_chk_count, c_sel_chg_count;
    logic [1:0]  c_first_err_sel;
    logic [7:0]  c_first_err_exp, c_first_err_got;

    mux_nx1_monitor #(.N_IN(4), .WIDTH(1), .LATENCY(0), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .bus(a_if.slave),
        .err_pulse(a_err_pulse), .illegal_sel(a_illegal_sel),
        .err_sticky(a_err_sticky), .err_count(a_err_count),
        .chk_count(a_chk_count), .sel_chg_count(a_sel_chg_count),
        .first_err_sel(a_first_err_sel), .first_err_exp(a_first_err_exp),
        .first_err_got(a_first_err_got)
    );

    mux_nx1_monitor #(.N_IN(4), .WIDTH(8), .LATENCY(2), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .bus(b_if.slave),
        .err_pulse(b_err_pulse), .illegal_sel(b_illegal_sel),
        .err_sticky(b_err_sticky), .err_count(b_err_count),
        .chk_count(b_chk_count), .sel_chg_count(b_sel_chg_count),
        .first_err_sel(b_first_err_sel), .first_err_exp(b_first_err_exp),
        .first_err_got(b_first_err_got)
    );

    mux_nx1_monitor #(.N_IN(3), .WIDTH(8), .LATENCY(3), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(c_clr), .bus(c_if.slave),
        .err_pulse(c_err_pulse), .illegal_sel(c_illegal_sel),
        .err_sticky(c_err_sticky), .err_count(c_err_count),
        .chk_count(c_chk_count), .sel_chg_count(c_sel_chg_count),
        .first_err_sel(c_first_err_sel), .first_err_exp(c_first_err_exp),
        .first_err_got(c_first_err_got)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] din_a;

    initial begin
        rst_n = 1'b0;
        a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
        a_if.en = 1'b0; a_if.din = '0; a_if.sel = '0; a_if.mux_out = '0;
        b_if.en = 1'b0; b_if.din = '0; b_if.sel = '0; b_if.mux_out = '0;
        c_if.en = 1'b0; c_if.din = '0; c_if.sel = '0; c_if.mux_out = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_a_chk",    a_chk_count, 0);
        check("rst_a_err",    a_err_count, 0);
        check("rst_a_sticky", a_err_sticky, 0);
        check("rst_b_pulse",  b_err_pulse, 0);

        // Test 1: ideal DUT, din=4'b1010, sel 0..3, LATENCY=0
        din_a    = 4'b1010;
        a_if.din = din_a;
        for (int s = 0; s < 4; s++) begin
            a_if.en      = 1'b1;
            a_if.sel     = 2'(s);
            a_if.mux_out = din_a[s];
            tick();
            check("t1_pulse", a_err_pulse, 0);
        end
        a_if.en = 1'b0;
        check("t1_err",     a_err_count, 0);
        check("t1_chk",     a_chk_count, 4);
        check("t1_selchg",  a_sel_chg_count, 3);
        check("t1_sticky",  a_err_sticky, 0);

        // Test 6: en gaps with sel 1,2,1 after clr
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check("t6_clr_chk", a_chk_count, 0);
        a_if.en = 1'b1; a_if.sel = 2'd1; a_if.mux_out = din_a[1];
        tick();
        a_if.en = 1'b0; a_if.sel = 2'd2; a_if.mux_out = 1'b0;
        tick();
        a_if.en = 1'b1; a_if.sel = 2'd1; a_if.mux_out = din_a[1];
        tick();
        a_if.en = 1'b0;
        check("t6_selchg", a_sel_chg_count, 0);
        check("t6_chk",    a_chk_count, 2);
        check("t6_err",    a_err_count, 0);

        // clr together with a failing compare: clr wins
        a_if.en = 1'b1; a_if.sel = 2'd0; a_if.mux_out = 1'b1; a_clr = 1'b1;
        tick();
        a_clr = 1'b0; a_if.en = 1'b0;
        check("t6_clrwin_err",    a_err_count, 0);
        check("t6_clrwin_pulse",  a_err_pulse, 0);
        check("t6_clrwin_sticky", a_err_sticky, 0);
        check("t6_clrwin_chk",    a_chk_count, 0);

        // A plain failing compare on the zero-latency instance
        a_if.en = 1'b1; a_if.sel = 2'd3; a_if.mux_out = 1'b0;
        tick();
        a_if.en = 1'b0;
        check("a_fail_pulse", a_err_pulse, 1);
        check("a_fail_cnt",   a_err_count, 1);
        check("a_fail_sel",   a_first_err_sel, 3);
        check("a_fail_exp",   a_first_err_exp, 1);
        check("a_fail_got",   a_first_err_got, 0);
        check("a_fail_ill",   a_illegal_sel, 0);
        tick();
        check("a_pulse_one",  a_err_pulse, 0);
        check("a_sticky_hold", a_err_sticky, 1);

        // Test 2: LATENCY=2, sel=2 at t=0, DUT answers 8'h00 at t=2
        b_if.din = 32'h4433_2211;
        b_if.en = 1'b1; b_if.sel = 2'd2; b_if.mux_out = 8'h00;
        tick();                                   // t=1
        b_if.en = 1'b0;
        tick();                                   // t=2
        check("t2_nopulse_t2", b_err_pulse, 0);
        b_if.mux_out = 8'h00;
        tick();                                   // t=3
        check("t2_pulse",  b_err_pulse, 1);
        check("t2_exp",    b_first_err_exp, 8'h33);
        check("t2_got",    b_first_err_got, 8'h00);
        check("t2_sel",    b_first_err_sel, 2);
        check("t2_sticky", b_err_sticky, 1);
        check("t2_err",    b_err_count, 1);

        // Back-to-back passing checks: sel 1 then 3
        b_if.en = 1'b1; b_if.sel = 2'd1;
        tick();
        check("t2_pulse_one", b_err_pulse, 0);
        b_if.sel = 2'd3;
        tick();
        b_if.en = 1'b0; b_if.mux_out = 8'h22;
        tick();
        b_if.mux_out = 8'h44;
        tick();
        check("t2_b2b_chk",    b_chk_count, 3);
        check("t2_b2b_err",    b_err_count, 1);
        check("t2_keep_exp",   b_first_err_exp, 8'h33);
        check("t2_selchg",     b_sel_chg_count, 2);

        // Test 3: N_IN=3, sel=3 is illegal even though mux_out reads 0
        c_if.din = 24'h33_2211;
        c_if.en = 1'b1; c_if.sel = 2'd3; c_if.mux_out = 8'h00;
        tick();
        c_if.en = 1'b0;
        tick();
        tick();
        check("t3_early", c_err_pulse, 0);
        tick();
        check("t3_illegal", c_illegal_sel, 1);
        check("t3_pulse",   c_err_pulse, 1);
        check("t3_exp",     c_first_err_exp, 0);
        check("t3_sel",     c_first_err_sel, 3);
        check("t3_got",     c_first_err_got, 0);

        // Test 4: CNT_W=4, 20 failing checks saturate at 4'hF
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        check("t4_clr_err", c_err_count, 0);
        c_if.en = 1'b1; c_if.sel = 2'd0; c_if.mux_out = 8'hFF;
        for (int k = 0; k < 20; k++) tick();
        c_if.en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("t4_err_sat", c_err_count, 4'hF);
        check("t4_chk_sat", c_chk_count, 4'hF);
        check("t4_sticky",  c_err_sticky, 1);
        check("t4_exp",     c_first_err_exp, 8'h11);
        check("t4_got",     c_first_err_got, 8'hFF);

        // Test 5: three failing samples in flight, then async reset
        for (int s = 0; s < 3; s++) begin
            c_if.en = 1'b1; c_if.sel = 2'(s); c_if.mux_out = 8'hFF;
            tick();
        end
        c_if.en = 1'b0;
        rst_n = 1'b0;
        #2;
        check("t5_rst_err",    c_err_count, 0);
        check("t5_rst_sticky", c_err_sticky, 0);
        check("t5_rst_exp",    c_first_err_exp, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_nopulse", c_err_pulse, 0);
        end
        check("t5_chk",    c_chk_count, 0);
        check("t5_err",    c_err_count, 0);
        check("t5_selchg", c_sel_chg_count, 0);
        check("t5_ill",    c_illegal_sel, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
